// File: rtl/clint_timer.sv
// Core-local interruptor for a single hart: 64-bit mtime with prescaler,
// mtimecmp, msip, and a one-cycle-latency 32-bit bus slave port.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [3:0]        req_sel_i,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              timer_irq_o,
    output logic              soft_irq_o,
    output logic [63:0]       mtime_o
);

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MSIP     = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] ADDR_MTCMP_LO = ADDR_W'(32'h0000_4000);
    localparam logic [ADDR_W-1:0] ADDR_MTCMP_HI = ADDR_W'(32'h0000_4004);
    localparam logic [ADDR_W-1:0] ADDR_MTIME_LO = ADDR_W'(32'h0000_BFF8);
    localparam logic [ADDR_W-1:0] ADDR_MTIME_HI = ADDR_W'(32'h0000_BFFC);
    localparam logic [15:0]       PRESC_LAST    = 16'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timer_irq_q, timer_irq_d;

    logic        tick;
    logic        accept;
    logic        wr_en;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d     = ST_IDLE;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        rdata_d     = 32'h0;
        rd_val      = 32'h0;

        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 16'h0 : presc_q + 16'h1;

        accept = (state_q == ST_IDLE) && req_valid_i;
        wr_en  = accept && req_we_i;

        if (accept) begin
            state_d = ST_RESP;
        end

        // Reads see register state before this cycle's tick or write.
        unique case (req_addr_i)
            ADDR_MSIP:     rd_val = {31'h0, msip_q};
            ADDR_MTCMP_LO: rd_val = mtimecmp_q[31:0];
            ADDR_MTCMP_HI: rd_val = mtimecmp_q[63:32];
            ADDR_MTIME_LO: rd_val = mtime_q[31:0];
            ADDR_MTIME_HI: rd_val = mtime_q[63:32];
            default:       rd_val = 32'h0;
        endcase

        if (accept && !req_we_i) begin
            rdata_d = rd_val;
        end

        if (wr_en && req_addr_i == ADDR_MSIP && req_sel_i[0]) begin
            msip_d = req_wdata_i[0];
        end
        if (wr_en && req_addr_i == ADDR_MTCMP_LO) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], req_wdata_i, req_sel_i);
        end
        if (wr_en && req_addr_i == ADDR_MTCMP_HI) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata_i, req_sel_i);
        end

        // A write to either mtime half suppresses the increment for that cycle.
        if (wr_en && req_addr_i == ADDR_MTIME_LO) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], req_wdata_i, req_sel_i);
        end else if (wr_en && req_addr_i == ADDR_MTIME_HI) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], req_wdata_i, req_sel_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'h1;
        end

        timer_irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            presc_q     <= 16'h0;
            rdata_q     <= 32'h0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            presc_q     <= presc_d;
            rdata_q     <= rdata_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign ack_o       = (state_q == ST_RESP);
    assign rdata_o     = rdata_q;
    assign timer_irq_o = timer_irq_q;
    assign soft_irq_o  = msip_q;
    assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: a TICK_DIV=1 instance driven over the bus
// and an idle TICK_DIV=4 instance whose mtime is checked against a cycle count.
module tb_clint_timer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        ack;
    logic [31:0] rdata;
    logic        timer_irq;
    logic        soft_irq;
    logic [63:0] mtime;

    logic        d4_valid;
    logic        d4_we;
    logic [15:0] d4_addr;
    logic [31:0] d4_wdata;
    logic [3:0]  d4_sel;
    logic        d4_ack;
    logic [31:0] d4_rdata;
    logic        d4_timer_irq;
    logic        d4_soft_irq;
    logic [63:0] d4_mtime;

    int          checks;
    int          errors;
    logic [63:0] cyc;

    logic        resp_ack;
    logic [31:0] resp_rdata;
    logic [63:0] resp_mtime;
    logic        resp_irq;
    logic        resp_soft;
    logic        ack_seen;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_sel_i   (req_sel),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .timer_irq_o (timer_irq),
        .soft_irq_o  (soft_irq),
        .mtime_o     (mtime)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) u_div4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (d4_valid),
        .req_we_i    (d4_we),
        .req_addr_i  (d4_addr),
        .req_wdata_i (d4_wdata),
        .req_sel_i   (d4_sel),
        .ack_o       (d4_ack),
        .rdata_o     (d4_rdata),
        .timer_irq_o (d4_timer_irq),
        .soft_irq_o  (d4_soft_irq),
        .mtime_o     (d4_mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset release; the idle TICK_DIV=4 timer should read cyc/4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'h0;
        else        cyc <= cyc + 64'h1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; request is accepted on the next posedge, the response
    // is captured at the following negedge, then one idle cycle lets the FSM return.
    task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] sel);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        @(posedge clk);
        @(negedge clk);
        resp_ack   = ack;
        resp_rdata = rdata;
        resp_mtime = mtime;
        resp_irq   = timer_irq;
        resp_soft  = soft_irq;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 32'h0;
        req_sel   = 4'h0;
        d4_valid  = 1'b0;
        d4_we     = 1'b0;
        d4_addr   = 16'h0;
        d4_wdata  = 32'h0;
        d4_sel    = 4'h0;
        ack_seen  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mtime", mtime, 64'h0);
        checkOutput("reset_irq", {63'h0, timer_irq}, 64'h0);
        checkOutput("reset_soft", {63'h0, soft_irq}, 64'h0);
        checkOutput("reset_ack", {63'h0, ack}, 64'h0);
        checkOutput("reset_rdata", {32'h0, rdata}, 64'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            ack_seen = ack_seen | ack;
            if (i == 9) checkOutput("idle10_mtime", mtime, 64'd10);
        end
        checkOutput("idle40_mtime", mtime, 64'd40);
        checkOutput("div4_40cyc_mtime", d4_mtime, 64'd10);
        checkOutput("idle_irq", {63'h0, timer_irq}, 64'h0);
        checkOutput("idle_soft", {63'h0, soft_irq}, 64'h0);
        checkOutput("idle_no_ack", {63'h0, ack_seen}, 64'h0);

        // mtimecmp = 50 while mtime is in the low 40s.
        applyStimulus(1'b1, 16'h4004, 32'h0, 4'hF);
        checkOutput("cmphi_ack", {63'h0, resp_ack}, 64'h1);
        checkOutput("cmphi_wr_rdata", {32'h0, resp_rdata}, 64'h0);
        applyStimulus(1'b1, 16'h4000, 32'd50, 4'hF);
        checkOutput("cmplo_ack", {63'h0, resp_ack}, 64'h1);
        checkOutput("cmplo_irq_low", {63'h0, resp_irq}, 64'h0);
        wait_cycles(5);
        checkOutput("mtime_49", mtime, 64'd49);
        checkOutput("irq_at_49", {63'h0, timer_irq}, 64'h0);
        wait_cycles(1);
        checkOutput("mtime_50", mtime, 64'd50);
        checkOutput("irq_at_50", {63'h0, timer_irq}, 64'h1);
        applyStimulus(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF);
        checkOutput("irq_drop_on_cmp", {63'h0, resp_irq}, 64'h0);

        applyStimulus(1'b1, 16'h0000, 32'h1, 4'hF);
        checkOutput("msip_set", {63'h0, resp_soft}, 64'h1);
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'h0);
        checkOutput("msip_rd_ack", {63'h0, resp_ack}, 64'h1);
        checkOutput("msip_rd", {32'h0, resp_rdata}, 64'h1);
        applyStimulus(1'b0, 16'h4000, 32'h0, 4'h0);
        checkOutput("cmplo_rd", {32'h0, resp_rdata}, 64'hFFFF_FFFF);
        applyStimulus(1'b1, 16'h0000, 32'h0, 4'hF);
        checkOutput("msip_clr", {63'h0, resp_soft}, 64'h0);
        applyStimulus(1'b1, 16'h0000, 32'h1, 4'hE);
        checkOutput("msip_lane0_gated", {63'h0, soft_irq}, 64'h0);
        applyStimulus(1'b1, 16'h4000, 32'h1122_3344, 4'h5);
        applyStimulus(1'b0, 16'h4000, 32'h0, 4'h0);
        checkOutput("cmplo_bytelanes", {32'h0, resp_rdata}, 64'hFF22_FF44);
        applyStimulus(1'b0, 16'h4004, 32'h0, 4'h0);
        checkOutput("cmphi_rd", {32'h0, resp_rdata}, 64'h0);

        // mtime writes land exactly; the unwritten half is left untouched.
        applyStimulus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        checkOutput("mtlo_wr_exact", resp_mtime, 64'h0000_0000_FFFF_FFFF);
        checkOutput("mtime_carry", mtime, 64'h0000_0001_0000_0000);
        applyStimulus(1'b1, 16'hBFFC, 32'h0, 4'hF);
        checkOutput("mthi_wr_no_inc", resp_mtime, 64'h0);
        checkOutput("mtime_after_hi", mtime, 64'h1);
        applyStimulus(1'b0, 16'hBFF8, 32'h0, 4'h0);
        checkOutput("mtlo_rd_preinc", {32'h0, resp_rdata}, 64'h1);
        checkOutput("mtime_during_rd", resp_mtime, 64'h2);
        applyStimulus(1'b0, 16'hBFFC, 32'h0, 4'h0);
        checkOutput("mthi_rd", {32'h0, resp_rdata}, 64'h0);
        applyStimulus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        checkOutput("mthi_wr_keep_lo", resp_mtime, 64'hFFFF_FFFF_0000_0005);
        applyStimulus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        checkOutput("mtime_all_ones", resp_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("irq_at_max", {63'h0, resp_irq}, 64'h1);
        checkOutput("mtime_wrap", mtime, 64'h0);
        checkOutput("irq_after_wrap", {63'h0, timer_irq}, 64'h0);

        applyStimulus(1'b0, 16'h1234, 32'h0, 4'h0);
        checkOutput("unmapped_rd_ack", {63'h0, resp_ack}, 64'h1);
        checkOutput("unmapped_rd", {32'h0, resp_rdata}, 64'h0);
        applyStimulus(1'b1, 16'h1234, 32'hFFFF_FFFF, 4'hF);
        checkOutput("unmapped_wr_ack", {63'h0, resp_ack}, 64'h1);
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'h0);
        checkOutput("unmapped_msip", {32'h0, resp_rdata}, 64'h0);
        applyStimulus(1'b0, 16'h4000, 32'h0, 4'h0);
        checkOutput("unmapped_cmplo", {32'h0, resp_rdata}, 64'hFF22_FF44);
        applyStimulus(1'b0, 16'h4004, 32'h0, 4'h0);
        checkOutput("unmapped_cmphi", {32'h0, resp_rdata}, 64'h0);
        checkOutput("div4_model", d4_mtime, cyc / 64'd4);

        // Reset lands while the read response is on the bus.
        applyStimulus(1'b1, 16'h0000, 32'h1, 4'hF);
        checkOutput("msip_before_rst", {63'h0, soft_irq}, 64'h1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h4000;
        @(posedge clk);
        #1;
        checkOutput("resp_before_rst", {63'h0, ack}, 64'h1);
        checkOutput("rdata_before_rst", {32'h0, rdata}, 64'hFF22_FF44);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("rst_ack", {63'h0, ack}, 64'h0);
        checkOutput("rst_rdata", {32'h0, rdata}, 64'h0);
        checkOutput("rst_soft", {63'h0, soft_irq}, 64'h0);
        checkOutput("rst_mtime", mtime, 64'h0);
        checkOutput("rst_irq", {63'h0, timer_irq}, 64'h0);
        checkOutput("rst_div4_mtime", d4_mtime, 64'h0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 16'h4000, 32'h0, 4'h0);
        checkOutput("rst_cmplo", {32'h0, resp_rdata}, 64'hFFFF_FFFF);
        applyStimulus(1'b0, 16'h4004, 32'h0, 4'h0);
        checkOutput("rst_cmphi", {32'h0, resp_rdata}, 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
